// File: rtl/lift_scheduler.sv
`default_nettype none
// ============================================================================
// lift_scheduler : SCAN-order single-car lift controller for floors 1..7.
// Optional door-hold input enabled by `define LIFT_SCHED_HOLD_EN.  Rev 1.0
// ============================================================================
module lift_scheduler #(
  parameter int MOVE_CYC = 4,
  parameter int DOOR_CYC = 3
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef LIFT_SCHED_HOLD_EN
  input  logic       door_hold_i,
`endif
  input  logic [2:0] pass_f,
  input  logic [2:0] butt_el,
  output logic [2:0] elev_f_o,
  output logic       busy_o,
  output logic       dir_o,
  output logic       door_o,
  output logic [7:0] pend_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  localparam logic [7:0] MOVE_LAST = 8'(MOVE_CYC - 1);
  localparam logic [7:0] DOOR_LAST = 8'(DOOR_CYC - 1);

  state_t     state, state_nx;
  logic [2:0] floor, floor_nx;
  logic       dir, dir_nx;
  logic [7:0] pend, pend_nx;
  logic [7:0] tmr, tmr_nx;   // shared: travel and door phases never overlap
  logic [7:0] req_set, req_clr;
  logic       decide, hold, arrive, door_req;
  logic [2:0] dec_f;
  logic [7:0] up_mask, dn_mask;
  logic       any_up, any_dn, here;

`ifdef LIFT_SCHED_HOLD_EN
  assign hold = door_hold_i;
`else
  assign hold = 1'b0;
`endif

  // Floor the scheduling decision is made for: the arrival floor on the
  // last travel edge, otherwise the floor the car is standing at.
  assign arrive  = ((state == MOVE_UP) || (state == MOVE_DOWN)) && (tmr == MOVE_LAST);
  assign dec_f   = !arrive ? floor : ((state == MOVE_UP) ? floor + 3'd1 : floor - 3'd1);
  assign up_mask = 8'hFE << dec_f;
  assign dn_mask = ((8'h01 << dec_f) - 8'h01) & 8'hFE;
  assign any_up  = |(pend & up_mask);
  assign any_dn  = |(pend & dn_mask);
  assign here    = pend[dec_f];

  assign door_req = (state == DOOR_OPEN) && ((pass_f == floor) || (butt_el == floor));

  always_comb begin
    state_nx = state;
    floor_nx = floor;
    dir_nx   = dir;
    tmr_nx   = tmr;
    req_set  = 8'h00;
    req_clr  = 8'h00;
    decide   = 1'b0;

    // Calls for the floor whose door is open are absorbed by the door restart.
    if ((pass_f != 3'd0) && !((state == DOOR_OPEN) && (pass_f == floor)))
      req_set[pass_f] = 1'b1;
    if ((butt_el != 3'd0) && !((state == DOOR_OPEN) && (butt_el == floor)))
      req_set[butt_el] = 1'b1;

    case (state)
      IDLE: decide = 1'b1;
      MOVE_UP, MOVE_DOWN: begin
        if (arrive) begin
          floor_nx = dec_f;
          decide   = 1'b1;
        end else begin
          tmr_nx = tmr + 8'd1;
        end
      end
      DOOR_OPEN: begin
        if (door_req) begin
          tmr_nx = 8'd0;
        end else if (!hold) begin
          if (tmr == DOOR_LAST) decide = 1'b1;
          else                  tmr_nx = tmr + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (decide) begin
      tmr_nx = 8'd0;
      if (here) begin
        state_nx = DOOR_OPEN;
        req_clr  = 8'h01 << dec_f;
      end else if ((dir && any_up) || (!dir && any_dn)) begin
        state_nx = dir ? MOVE_UP : MOVE_DOWN;
      end else if (any_up) begin
        dir_nx   = 1'b1;
        state_nx = MOVE_UP;
      end else if (any_dn) begin
        dir_nx   = 1'b0;
        state_nx = MOVE_DOWN;
      end else begin
        state_nx = IDLE;
      end
    end

    // A stop clears its floor even if the same call is sampled on that edge.
    pend_nx = (pend | req_set) & ~req_clr & 8'hFE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      floor <= 3'd1;
      dir   <= 1'b1;
      pend  <= 8'h00;
      tmr   <= 8'd0;
    end else begin
      state <= state_nx;
      floor <= floor_nx;
      dir   <= dir_nx;
      pend  <= pend_nx;
      tmr   <= tmr_nx;
    end
  end

  assign elev_f_o = floor;
  assign busy_o   = (state != IDLE);
  assign dir_o    = dir;
  assign door_o   = (state == DOOR_OPEN);
  assign pend_o   = pend;

endmodule
`default_nettype wire

// File: tb/tb_lift_scheduler.sv
`default_nettype none
// tb_lift_scheduler : directed scenarios plus randomized calls checked against a
// floor-level reference model of the lift.
module tb_lift_scheduler;

  localparam int MOVE_CYC = 4;
  localparam int DOOR_CYC = 3;
  localparam int MD_IDLE  = 0;
  localparam int MD_MOVE  = 1;
  localparam int MD_DOOR  = 2;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b1;
  logic [2:0] pass_f    = 3'd0;
  logic [2:0] butt_el   = 3'd0;
  logic       door_hold = 1'b0;
  logic [2:0] elev_f_o;
  logic       busy_o, dir_o, door_o;
  logic [7:0] pend_o;

  int tests = 0;
  int fails = 0;

  // Reference model: car position, direction, activity, phase counter, calls.
  int m_floor, m_dir, m_mode, m_t;
  bit m_pend [8];

  lift_scheduler #(.MOVE_CYC(MOVE_CYC), .DOOR_CYC(DOOR_CYC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef LIFT_SCHED_HOLD_EN
    .door_hold_i (door_hold),
`endif
    .pass_f   (pass_f),
    .butt_el  (butt_el),
    .elev_f_o (elev_f_o),
    .busy_o   (busy_o),
    .dir_o    (dir_o),
    .door_o   (door_o),
    .pend_o   (pend_o)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] obs_vec();
    return {elev_f_o, dir_o, busy_o, door_o, pend_o};
  endfunction

  function automatic logic [13:0] exp_vec();
    logic [7:0] p;
    p = 8'h00;
    for (int k = 1; k < 8; k++) p[k] = m_pend[k];
    return {3'(m_floor), (m_dir == 1), (m_mode != MD_IDLE), (m_mode == MD_DOOR), p};
  endfunction

  task automatic model_reset();
    m_floor = 1; m_dir = 1; m_mode = MD_IDLE; m_t = 0;
    for (int k = 0; k < 8; k++) m_pend[k] = 1'b0;
  endtask

  task automatic model_edge(input int pf, input int be);
    bit old [8];
    int f0, up, dn;
    bit was_door, decide;
    old      = m_pend;
    f0       = m_floor;
    was_door = (m_mode == MD_DOOR);
    decide   = 1'b0;
    if (m_mode == MD_IDLE) begin
      decide = 1'b1;
    end else if (m_mode == MD_MOVE) begin
      if (m_t == MOVE_CYC - 1) begin
        m_floor = m_floor + ((m_dir == 1) ? 1 : -1);
        decide  = 1'b1;
      end else m_t++;
    end else begin
      if (pf == f0 || be == f0) m_t = 0;
      else if (!door_hold) begin
        if (m_t == DOOR_CYC - 1) decide = 1'b1;
        else m_t++;
      end
    end
    if (pf != 0 && !(was_door && pf == f0)) m_pend[pf] = 1'b1;
    if (be != 0 && !(was_door && be == f0)) m_pend[be] = 1'b1;
    if (decide) begin
      m_t = 0; up = 0; dn = 0;
      for (int k = 1; k < 8; k++) begin
        if (old[k] && k > m_floor) up++;
        if (old[k] && k < m_floor) dn++;
      end
      if (old[m_floor]) begin
        m_mode = MD_DOOR;
        m_pend[m_floor] = 1'b0;
      end else if ((m_dir == 1 && up > 0) || (m_dir == 0 && dn > 0)) m_mode = MD_MOVE;
      else if (up > 0) begin m_dir = 1; m_mode = MD_MOVE; end
      else if (dn > 0) begin m_dir = 0; m_mode = MD_MOVE; end
      else m_mode = MD_IDLE;
    end
  endtask

  // Drive calls for one edge (entered and left at a falling edge).
  task automatic cycle(input int pf, input int be);
    pass_f  = 3'(pf);
    butt_el = 3'(be);
    @(posedge clk);
    model_edge(pf, be);
    @(negedge clk);
    pass_f  = 3'd0;
    butt_el = 3'd0;
  endtask

  task automatic hard_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs until the car goes idle; reports stop sequence (octal digits),
  // first door length, direction at last stop and model disagreements.
  task automatic run_trip(input int inj_at, input int inj_floor, output int seq,
                          output int first_len, output int last_dir, output int bad,
                          output bit timeout);
    bit prev_door;
    int stops;
    seq = 0; first_len = 0; last_dir = -1; bad = 0; timeout = 1'b1;
    prev_door = door_o; stops = 0;
    for (int i = 0; i < 300; i++) begin
      cycle((i == inj_at) ? inj_floor : 0, 0);
      if (obs_vec() !== exp_vec()) bad++;
      if (door_o && !prev_door) begin
        seq = seq * 8 + int'(elev_f_o);
        last_dir = int'(dir_o);
        stops++;
      end
      if (door_o && stops == 1) first_len++;
      prev_door = door_o;
      if (!busy_o) begin timeout = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    logic [13:0] want;
    #1;
    hard_reset();
    want = {3'd1, 1'b1, 1'b0, 1'b0, 8'h00};
    tests++;
    if (obs_vec() !== want) begin
      fails++; $display("FAIL reset_state: got %h want %h", obs_vec(), want);
    end
    tests++;
    if (obs_vec() !== exp_vec()) begin
      fails++; $display("FAIL reset_model: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_single_call();
    cycle(3, 0);
    tests++;
    if (pend_o !== 8'h08) begin
      fails++; $display("FAIL single_call_pend: got %h want 08", pend_o);
    end
    for (int e = 1; e <= 12; e++) begin
      cycle(0, 0);
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL single_call_model e%0d: got %h want %h", e, obs_vec(), exp_vec());
      end
      if (e == 1 || e == 4) begin
        tests++;
        if ({busy_o, door_o, elev_f_o} !== {1'b1, 1'b0, 3'd1}) begin
          fails++; $display("FAIL single_call_e%0d: busy/door/floor got %b%b%0d want 1 0 1", e, busy_o, door_o, elev_f_o);
        end
      end
      if (e == 5) begin
        tests++;
        if ({busy_o, door_o, elev_f_o} !== {1'b1, 1'b0, 3'd2}) begin
          fails++; $display("FAIL single_call_e5: busy/door/floor got %b%b%0d want 1 0 2", busy_o, door_o, elev_f_o);
        end
      end
      if (e == 9 || e == 11) begin
        tests++;
        if ({door_o, elev_f_o, pend_o} !== {1'b1, 3'd3, 8'h00}) begin
          fails++; $display("FAIL single_call_e%0d: door/floor/pend got %b %0d %h want 1 3 00", e, door_o, elev_f_o, pend_o);
        end
      end
      if (e == 12) begin
        tests++;
        if ({busy_o, door_o, elev_f_o, pend_o} !== {1'b0, 1'b0, 3'd3, 8'h00}) begin
          fails++; $display("FAIL single_call_e12: busy/door/floor/pend got %b%b %0d %h want 0 0 3 00", busy_o, door_o, elev_f_o, pend_o);
        end
      end
    end
  endtask

  task automatic test_same_cycle();
    int seq, len, ldir, bad;
    bit to;
    cycle(5, 7);
    tests++;
    if (pend_o !== 8'hA0) begin
      fails++; $display("FAIL same_cycle_pend: got %h want a0", pend_o);
    end
    run_trip(-1, 0, seq, len, ldir, bad, to);
    tests++;
    if (to !== 1'b0 || bad != 0) begin
      fails++; $display("FAIL same_cycle_run: timeout %0d model_errors %0d want 0 0", to, bad);
    end
    tests++;
    if (seq != 'o57) begin
      fails++; $display("FAIL same_cycle_order: stops %0o want 57", seq);
    end
    tests++;
    if (len != DOOR_CYC) begin
      fails++; $display("FAIL same_cycle_door5: got %0d cycles want %0d", len, DOOR_CYC);
    end
  endtask

  task automatic test_reversal();
    int seq, len, ldir, bad;
    bit to;
    cycle(3, 0);
    run_trip(-1, 0, seq, len, ldir, bad, to);
    tests++;
    if (to !== 1'b0 || bad != 0 || seq != 'o3 || ldir != 0) begin
      fails++; $display("FAIL reversal_descend: timeout %0d errs %0d stops %0o dir %0d want 0 0 3 0", to, bad, seq, ldir);
    end
    cycle(0, 7);
    run_trip(5, 2, seq, len, ldir, bad, to);
    tests++;
    if (to !== 1'b0 || bad != 0) begin
      fails++; $display("FAIL reversal_run: timeout %0d model_errors %0d want 0 0", to, bad);
    end
    tests++;
    if (seq != 'o72 || ldir != 0) begin
      fails++; $display("FAIL reversal_scan: stops %0o dir_at_last %0d want 72 0", seq, ldir);
    end
  endtask

  task automatic test_door_restart();
    int len;
    hard_reset();
    cycle(1, 0);
    len = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0);
      if (door_o) len++;
      else if (len > 0) break;
    end
    tests++;
    if (len != DOOR_CYC || elev_f_o !== 3'd1) begin
      fails++; $display("FAIL door_plain: got %0d cycles at floor %0d want %0d at 1", len, elev_f_o, DOOR_CYC);
    end
    cycle(1, 0);
    cycle(0, 0);
    tests++;
    if ({door_o, elev_f_o, pend_o} !== {1'b1, 3'd1, 8'h00}) begin
      fails++; $display("FAIL door_open_next: door/floor/pend got %b %0d %h want 1 1 00", door_o, elev_f_o, pend_o);
    end
    cycle(0, 0);
    cycle(1, 0);
    tests++;
    if ({door_o, pend_o} !== {1'b1, 8'h00}) begin
      fails++; $display("FAIL door_restart_pend: door/pend got %b %h want 1 00", door_o, pend_o);
    end
    len = 3;
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0);
      if (door_o) len++;
      else break;
    end
    tests++;
    if (len != 5 || elev_f_o !== 3'd1 || obs_vec() !== exp_vec()) begin
      fails++; $display("FAIL door_restart_len: got %0d cycles floor %0d state %h want 5 1 %h", len, elev_f_o, obs_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid_travel();
    bit found;
    cycle(7, 5);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cycle(0, 0);
      if (elev_f_o == 3'd4) begin found = 1'b1; break; end
    end
    cycle(0, 0);
    cycle(0, 0);
    tests++;
    if (!found || busy_o !== 1'b1 || door_o !== 1'b0 || pend_o !== 8'hA0) begin
      fails++; $display("FAIL midtravel_setup: found %0d busy %b door %b pend %h want 1 1 0 a0", found, busy_o, door_o, pend_o);
    end
    @(posedge clk);
    #2;
    rst_n  = 1'b0;
    pass_f = 3'd6;
    #1;
    tests++;
    if (obs_vec() !== {3'd1, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      fails++; $display("FAIL midtravel_async_reset: got %h want %h", obs_vec(), {3'd1, 1'b1, 1'b0, 1'b0, 8'h00});
    end
    model_reset();
    repeat (2) @(negedge clk);
    pass_f = 3'd0;
    rst_n  = 1'b1;
    cycle(0, 0);
    tests++;
    if (pend_o !== 8'h00 || obs_vec() !== exp_vec()) begin
      fails++; $display("FAIL midtravel_no_sample: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

`ifdef LIFT_SCHED_HOLD_EN
  task automatic test_hold();
    int len;
    hard_reset();
    cycle(1, 0);
    cycle(0, 0);
    len = door_o ? 1 : 0;
    door_hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0);
      if (door_o) len++;
    end
    door_hold = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0);
      if (door_o) len++;
      else break;
    end
    tests++;
    if (len != DOOR_CYC + 10 || obs_vec() !== exp_vec()) begin
      fails++; $display("FAIL door_hold: got %0d cycles state %h want %0d %h", len, obs_vec(), DOOR_CYC + 10, exp_vec());
    end
  endtask
`endif

  task automatic test_random();
    int pf, be;
    hard_reset();
    for (int i = 0; i < 3000; i++) begin
      pf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      be = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 0;
`ifdef LIFT_SCHED_HOLD_EN
      door_hold = ($urandom_range(0, 7) == 0);
`endif
      cycle(pf, be);
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL random_c%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      tests++;
      if (elev_f_o < 3'd1 || elev_f_o > 3'd7 || pend_o[0] !== 1'b0) begin
        fails++; $display("FAIL random_bounds_c%0d: floor %0d pend %h want floor 1..7 bit0 0", i, elev_f_o, pend_o);
      end
    end
    door_hold = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_call();
    test_same_cycle();
    test_reversal();
    test_door_restart();
    test_reset_mid_travel();
`ifdef LIFT_SCHED_HOLD_EN
    test_hold();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
